string_echo_responder: RTL and testbench

DUT-side responder for the byte/string stream that the verification environment's driver produces from string and file sequences. It receives framed bytes over a valid/ready interface and stores each whole frame (store-and-forward). It then echoes the frame on an output valid/ready stream for the monitor and scoreboard to check, and reports per-frame length, checksum and truncation status.

---
 rtl/string_echo_responder_if.sv | 33 +++
 rtl/string_echo_responder.sv | 115 +++++++++++
 tb/tb_string_echo_responder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/string_echo_responder_if.sv
// Byte-stream bundle for string_echo_responder.
// Carries the input byte stream (in_*), the echo stream (out_*) and the
// per-frame status outputs (frame_*).
//   master : stimulus side. Drives in_valid/in_data/in_last and out_ready.
//   slave  : responder side. Drives in_ready, out_* and frame_*.
interface string_echo_responder_if #(
    parameter int unsigned LEN_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;
    logic             frame_done;
    logic [LEN_W-1:0] frame_len;
    logic [7:0]       frame_sum;
    logic             frame_trunc;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last,
        input  frame_done, frame_len, frame_sum, frame_trunc
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last,
        output frame_done, frame_len, frame_sum, frame_trunc
    );
endinterface

// File: rtl/string_echo_responder.sv
// Store-and-forward byte-frame echo responder.
// Accepts a whole frame on the input stream, storing up to DEPTH bytes, then
// echoes the stored bytes on the output stream and reports the frame's full
// accepted length, byte sum (mod 256) and whether it overflowed the buffer.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of string_echo_responder_if (in_*, out_*, frame_*)
module string_echo_responder #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LEN_W = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    string_echo_responder_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] StRecv = 1'b0;
    localparam logic [0:0] StSend = 1'b1;

    logic [0:0]       state_q;
    logic [CNT_W-1:0] wr_cnt_q;  // bytes stored this frame, caps at DEPTH
    logic [CNT_W-1:0] rd_cnt_q;  // bytes echoed this frame
    logic [LEN_W-1:0] len_q;
    logic [7:0]       sum_q;
    logic             ovf_q;
    logic             frame_done_q;
    logic [LEN_W-1:0] frame_len_q;
    logic [7:0]       frame_sum_q;
    logic             frame_trunc_q;
    logic [7:0]       mem [DEPTH];

    logic in_fire;
    logic out_fire;
    logic send_last;
    logic store_en;

    assign bus.in_ready  = (state_q == StRecv);
    assign bus.out_valid = (state_q == StSend);
    // wr_cnt_q is at least 1 whenever SEND is entered, so no underflow here.
    assign send_last     = (rd_cnt_q == wr_cnt_q - CNT_W'(1));
    assign bus.out_last  = (state_q == StSend) && send_last;
    assign bus.out_data  = (state_q == StSend) ? mem[rd_cnt_q[PTR_W-1:0]] : 8'h00;

    assign bus.frame_done  = frame_done_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.frame_sum   = frame_sum_q;
    assign bus.frame_trunc = frame_trunc_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;
    assign store_en = in_fire && (wr_cnt_q < CNT_W'(DEPTH));

    // Buffer has no reset; contents are only read for bytes written this frame.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[wr_cnt_q[PTR_W-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRecv;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            len_q         <= '0;
            sum_q         <= '0;
            ovf_q         <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_len_q   <= '0;
            frame_sum_q   <= '0;
            frame_trunc_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                StRecv: begin
                    if (in_fire) begin
                        if (len_q != {LEN_W{1'b1}}) begin
                            len_q <= len_q + LEN_W'(1);
                        end
                        sum_q <= sum_q + bus.in_data;
                        if (store_en) begin
                            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                        if (bus.in_last) begin
                            state_q <= StSend;
                        end
                    end
                end
                StSend: begin
                    if (out_fire) begin
                        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                        if (send_last) begin
                            frame_done_q  <= 1'b1;
                            frame_len_q   <= len_q;
                            frame_sum_q   <= sum_q;
                            frame_trunc_q <= ovf_q;
                            wr_cnt_q      <= '0;
                            rd_cnt_q      <= '0;
                            len_q         <= '0;
                            sum_q         <= '0;
                            ovf_q         <= 1'b0;
                            state_q       <= StRecv;
                        end
                    end
                end
                default: state_q <= StRecv;
            endcase
        end
    end
endmodule

// File: tb/tb_string_echo_responder.sv
module tb_string_echo_responder;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LEN_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    string_echo_responder_if #(.LEN_W(LEN_W)) bus ();

    string_echo_responder #(
        .DEPTH(DEPTH),
        .LEN_W(LEN_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] frame_q[$];

    // Drive frame_q onto the input stream; ends #1 after the in_last edge.
    task automatic drive_frame(input bit gaps);
        for (int i = 0; i < frame_q.size(); i++) begin
            bit accepted;
            int guard;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = frame_q[i];
            bus.in_last  = (i == frame_q.size() - 1);
            accepted = 1'b0;
            guard = 0;
            while (!accepted && guard < 50) begin
                accepted = bus.in_ready;
                @(posedge clk); #1;
                guard++;
            end
            n_cmp++;
            if (!accepted) begin
                n_fail++;
                $display("FAIL in_accept byte %0d: in_ready=0, required 1", i);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL echo_latency: out_valid=%b, required 1", bus.out_valid);
        end
    endtask

    // Reference: echo = first min(N,DEPTH) bytes; len = N; sum = sum mod 256;
    // trunc = N > DEPTH. mode 0: always ready, 1: ready 1,0,0,... 2: random.
    task automatic collect_echo(input int mode, input bit hold_check);
        int n;
        int exp_n;
        int idx;
        int cyc;
        logic [7:0] exp_sum;
        bit go;
        n = frame_q.size();
        exp_n = (n > DEPTH) ? DEPTH : n;
        exp_sum = 8'h00;
        foreach (frame_q[i]) exp_sum = exp_sum + frame_q[i];
        idx = 0;
        cyc = 0;
        while (idx < exp_n && cyc < 500) begin
            case (mode)
                0:       go = 1'b1;
                1:       go = (cyc % 3 == 0);
                default: go = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = go;
            // Junk input traffic during SEND must be ignored.
            if (go && idx == exp_n - 1) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
            end else begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = 8'($urandom);
                bus.in_last  = 1'($urandom_range(0, 1));
            end
            #1;
            n_cmp += 5;
            if (bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL echo_valid idx %0d: got %b, required 1", idx, bus.out_valid);
            end
            if (bus.out_data !== frame_q[idx]) begin
                n_fail++;
                $display("FAIL echo_data idx %0d: got %h, required %h", idx, bus.out_data,
                         frame_q[idx]);
            end
            if (bus.out_last !== 1'(idx == exp_n - 1)) begin
                n_fail++;
                $display("FAIL echo_last idx %0d: got %b, required %b", idx, bus.out_last,
                         (idx == exp_n - 1));
            end
            if (bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL send_in_ready idx %0d: got %b, required 0", idx, bus.in_ready);
            end
            if (bus.frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL early_done idx %0d: got %b, required 0", idx, bus.frame_done);
            end
            @(posedge clk); #1;
            if (go) idx++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_cmp++;
        if (idx < exp_n) begin
            n_fail++;
            $display("FAIL echo_timeout: got %0d bytes, required %0d", idx, exp_n);
        end
        n_cmp += 6;
        if (bus.frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_done: got %b, required 1", bus.frame_done);
        end
        if (bus.frame_len !== LEN_W'(n)) begin
            n_fail++;
            $display("FAIL frame_len: got %0d, required %0d", bus.frame_len, n);
        end
        if (bus.frame_sum !== exp_sum) begin
            n_fail++;
            $display("FAIL frame_sum: got %h, required %h", bus.frame_sum, exp_sum);
        end
        if (bus.frame_trunc !== 1'(n > DEPTH)) begin
            n_fail++;
            $display("FAIL frame_trunc: got %b, required %b", bus.frame_trunc, (n > DEPTH));
        end
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_done: got %b, required 1", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_after_done: got %b, required 0", bus.out_valid);
        end
        if (hold_check) begin
            @(posedge clk); #1;
            n_cmp += 2;
            if (bus.frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse_width: got %b, required 0", bus.frame_done);
            end
            if (bus.frame_len !== LEN_W'(n)) begin
                n_fail++;
                $display("FAIL status_hold: len %0d, required %0d", bus.frame_len, n);
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp += 8;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b, required 0", bus.out_last); end
        if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h, required 00", bus.out_data); end
        if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", bus.frame_done); end
        if (bus.frame_len !== '0) begin n_fail++; $display("FAIL rst_len: got %0d, required 0", bus.frame_len); end
        if (bus.frame_sum !== 8'h00) begin n_fail++; $display("FAIL rst_sum: got %h, required 00", bus.frame_sum); end
        if (bus.frame_trunc !== 1'b0) begin n_fail++; $display("FAIL rst_trunc: got %b, required 0", bus.frame_trunc); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input int mode);
        frame_q = '{8'h41, 8'h42, 8'h43};
        drive_frame(1'b0);
        collect_echo(mode, 1'b1);
    endtask

    task automatic test_truncated();
        frame_q.delete();
        for (int i = 1; i <= 20; i++) frame_q.push_back(8'(i));
        drive_frame(1'b0);
        collect_echo(0, 1'b1);
    endtask

    task automatic test_exact_depth();
        frame_q.delete();
        repeat (DEPTH) frame_q.push_back(8'hFF);
        drive_frame(1'b0);
        collect_echo(0, 1'b1);
    endtask

    task automatic test_back_to_back();
        frame_q = '{8'h00};
        drive_frame(1'b0);
        collect_echo(0, 1'b0);
        frame_q = '{8'h7F};
        drive_frame(1'b0);
        collect_echo(0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h11;
        @(posedge clk); #1;
        bus.in_data  = 8'h22;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp += 5;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b, required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.frame_len !== '0) begin n_fail++; $display("FAIL mid_rst_len: got %0d, required 0", bus.frame_len); end
        if (bus.frame_sum !== 8'h00) begin n_fail++; $display("FAIL mid_rst_sum: got %h, required 00", bus.frame_sum); end
        if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b, required 0", bus.frame_done); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame_q = '{8'h55};
        drive_frame(1'b0);
        collect_echo(0, 1'b1);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(1, 40);
            frame_q.delete();
            repeat (n) frame_q.push_back(8'($urandom));
            drive_frame(1'b1);
            collect_echo(2, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic(0);
        test_basic(1);
        test_truncated();
        test_exact_depth();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
